// File: rtl/alu_mul_seq.sv
// Sequential shift-add multiplier (32x32 -> low 32) that borrows the shared ALU.
// Optional MUL_EARLY_TERM_EN: finish as soon as the remaining multiplier is zero.
module alu_mul_seq #(
    parameter int unsigned ITERS  = 32,
    parameter logic [5:0]  OP_ADD = 6'h20,
    parameter logic [5:0]  OP_SLL = 6'h04,
    parameter logic [5:0]  OP_SRL = 6'h06
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        ready,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [5:0]  alu_opcode,
    input  logic [31:0] alu_out
);

    localparam int unsigned W  = 32;
    localparam int unsigned CW = 6;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        ADD   = 3'd2,
        SHL   = 3'd3,
        SHR   = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t          state, state_n;
    logic [W-1:0]    acc, acc_n;
    logic [W-1:0]    mcand, mcand_n;
    logic [W-1:0]    mplier, mplier_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [W-1:0]    result_n;
    logic            finish_c;

    // Loop exit condition; early termination stops once no multiplier bits remain
`ifdef MUL_EARLY_TERM_EN
    assign finish_c = (cnt == CW'(ITERS)) || (mplier == '0);
`else
    assign finish_c = (cnt == CW'(ITERS));
`endif

    // Next-state, datapath updates and ALU steering
    always_comb begin
        state_n    = state;
        acc_n      = acc;
        mcand_n    = mcand;
        mplier_n   = mplier;
        cnt_n      = cnt;
        result_n   = result;
        alu_a      = '0;
        alu_b      = '0;
        alu_opcode = OP_ADD;

        case (state)
            IDLE: begin
                if (start) begin
                    mcand_n  = op_a;
                    mplier_n = op_b;
                    acc_n    = '0;
                    cnt_n    = '0;
                    state_n  = CHECK;
                end
            end
            CHECK: begin
                if (finish_c) begin
                    result_n = acc;
                    state_n  = DONE;
                end else if (mplier[0]) begin
                    state_n = ADD;
                end else begin
                    state_n = SHL;
                end
            end
            ADD: begin
                alu_a      = acc;
                alu_b      = mcand;
                alu_opcode = OP_ADD;
                acc_n      = alu_out;
                state_n    = SHL;
            end
            SHL: begin
                alu_a      = mcand;
                alu_b      = W'(1);
                alu_opcode = OP_SLL;
                mcand_n    = alu_out;
                state_n    = SHR;
            end
            SHR: begin
                alu_a      = mplier;
                alu_b      = W'(1);
                alu_opcode = OP_SRL;
                mplier_n   = alu_out;
                cnt_n      = cnt + CW'(1);
                state_n    = CHECK;
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State and datapath registers; handshake flags follow the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            result <= '0;
            ready  <= 1'b1;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_n;
            acc    <= acc_n;
            mcand  <= mcand_n;
            mplier <= mplier_n;
            cnt    <= cnt_n;
            result <= result_n;
            ready  <= (state_n == IDLE);
            busy   <= (state_n != IDLE);
            done   <= (state_n == DONE);
        end
    end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed bench for alu_mul_seq with a behavioural ALU on the alu_* port.
module tb_alu_mul_seq;

    localparam logic [5:0] OP_ADD = 6'h20;
    localparam logic [5:0] OP_SLL = 6'h04;
    localparam logic [5:0] OP_SRL = 6'h06;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] op_a, op_b;
    logic        ready, busy, done;
    logic [31:0] result;
    logic [31:0] alu_a, alu_b, alu_out;
    logic [5:0]  alu_opcode;

    int tests = 0;
    int fails = 0;
    logic [5:0] seq[$];
    logic [5:0] exp_seq[8];
    int lat, adds;
    bit saw_done, saw_shl;

    always #5 clk = ~clk;

    alu_mul_seq dut (
        .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
        .ready(ready), .busy(busy), .done(done), .result(result),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_out(alu_out)
    );

    function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [5:0] op);
        case (op)
            OP_ADD:  return a + b;
            OP_SLL:  return a << b[4:0];
            OP_SRL:  return a >> b[4:0];
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    always_comb alu_out = alu_model(alu_a, alu_b, alu_opcode);

    function automatic int popc(input logic [31:0] b);
        int n = 0;
        for (int i = 0; i < 32; i++) n += int'(b[i]);
        return n;
    endfunction

    function automatic int exp_iters(input logic [31:0] b);
`ifdef MUL_EARLY_TERM_EN
        int n = 0;
        for (int i = 0; i < 32; i++) if (b[i]) n = i + 1;
        return n;
`else
        return 32;
`endif
    endfunction

    function automatic int exp_lat(input logic [31:0] b);
        return 3 * exp_iters(b) + popc(b) + 2;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One multiply from IDLE; caller is positioned 1 time unit after a rising edge
    task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp,
                           input bit hold, output int lat_o, output int adds_o);
        seq.delete();
        adds_o = 0;
        lat_o  = 0;
        start  = 1'b1;
        op_a   = a;
        op_b   = b;
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        op_a = ~a;
        op_b = ~b;
        chk("accept_ready", 32'(ready), 32'd0);
        chk("accept_busy", 32'(busy), 32'd1);
        for (int c = 1; c <= 200; c++) begin
            if (done) begin
                lat_o = c;
                break;
            end
            if (alu_opcode != OP_ADD || alu_b != 32'd0) begin
                seq.push_back(alu_opcode);
                if (alu_opcode == OP_ADD) adds_o++;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        if (lat_o == 0) begin
            chk("done_timeout", 32'(done), 32'd1);
        end else begin
            chk("done_result", result, exp);
            chk("done_busy", 32'(busy), 32'd1);
            chk("done_ready", 32'(ready), 32'd0);
            @(posedge clk); #1;
            chk("post_ready", 32'(ready), 32'd1);
            chk("post_busy", 32'(busy), 32'd0);
            chk("post_done", 32'(done), 32'd0);
            chk("post_result_held", result, exp);
        end
    endtask

    initial begin
        exp_seq = '{OP_ADD, OP_SLL, OP_SRL, OP_SLL, OP_SRL, OP_ADD, OP_SLL, OP_SRL};
        rst   = 1'b1;
        start = 1'b1;
        op_a  = 32'd4;
        op_b  = 32'd4;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_alu_b", alu_b, 32'd0);
        chk("rst_opcode", 32'(alu_opcode), 32'(OP_ADD));
        rst   = 1'b0;
        start = 1'b0;
        @(posedge clk); #1;

        // 3 * 5: opcode sequence, latency, ADD count
        run_mul(32'd3, 32'd5, 32'd15, 1'b0, lat, adds);
        chk("mul3x5_lat", 32'(lat), 32'(exp_lat(32'd5)));
        chk("mul3x5_adds", 32'(adds), 32'd2);
        chk("mul3x5_seqlen", 32'(seq.size()), 32'(2 * exp_iters(32'd5) + 2));
        for (int i = 0; i < 8; i++)
            chk($sformatf("mul3x5_seq%0d", i), 32'(i < seq.size() ? seq[i] : 6'h3f),
                32'(exp_seq[i]));

        // Overflow wraps modulo 2^32
        run_mul(32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 1'b0, lat, adds);
        chk("mulffx2_lat", 32'(lat), 32'(exp_lat(32'd2)));
        run_mul(32'h8000_0000, 32'd2, 32'd0, 1'b0, lat, adds);
        chk("mul80x2_lat", 32'(lat), 32'(exp_lat(32'd2)));

        // Zero multiplier: no ADD ever issued
        run_mul(32'h0000_1234, 32'd0, 32'd0, 1'b0, lat, adds);
        chk("mulx0_lat", 32'(lat), 32'(exp_lat(32'd0)));
        chk("mulx0_adds", 32'(adds), 32'd0);

        // start held high through a 7*6 multiply; only the first request counts
        run_mul(32'd7, 32'd6, 32'd42, 1'b1, lat, adds);
        chk("mul7x6_lat", 32'(lat), 32'(exp_lat(32'd6)));

        // Reset during the SHL of 9*9 aborts silently
        saw_done = 1'b0;
        saw_shl  = 1'b0;
        start = 1'b1;
        op_a  = 32'd9;
        op_b  = 32'd9;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (done) saw_done = 1'b1;
            if (alu_opcode == OP_SLL) begin
                saw_shl = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        chk("rst_mid_found_shl", 32'(saw_shl), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_mid_ready", 32'(ready), 32'd1);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_done", 32'(done), 32'd0);
        chk("rst_mid_result", result, 32'd0);
        chk("rst_mid_opcode", 32'(alu_opcode), 32'(OP_ADD));
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (done || !ready) saw_done = 1'b1;
        end
        chk("rst_mid_quiet", 32'(saw_done), 32'd0);

        run_mul(32'd2, 32'd3, 32'd6, 1'b0, lat, adds);
        chk("mul2x3_lat", 32'(lat), 32'(exp_lat(32'd3)));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_mul_seq.md
Name: alu_mul_seq

Overview:
- Multi-cycle controller that implements DLX MUL (func 0x0e, 32x32 -> low 32 bits) by sequencing the existing combinational 32-bit ALU through shift-add iterations.
- Sits beside the ALU and owns its A/B/opcode inputs while a multiply is in flight.
- Uses only ALU ops ADD (0x20), SLL (0x04) and SRL (0x06).
- Start/done handshake toward the pipeline control.

Parameters:
- ITERS, 32, maximum shift-add iterations (multiplier bits examined).
- OP_ADD, 6'h20, ALU func code for ADD.
- OP_SLL, 6'h04, ALU func code for SLL.
- OP_SRL, 6'h06, ALU func code for SRL.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a multiply; accepted only when ready=1.
- op_a  input  32  multiplicand; sampled on the accept edge.
- op_b  input  32  multiplier; sampled on the accept edge.
- ready  output  1  high in IDLE only.
- busy  output  1  high from the accept edge until DONE is left.
- done  output  1  one-cycle pulse; result valid.
- result  output  32  product low word; held until the next accept or reset.
- alu_a  output  32  drives ALU A.
- alu_b  output  32  drives ALU B.
- alu_opcode  output  6  drives ALU opcode.
- alu_out  input  32  ALU result, combinational in the same cycle.

Behaviour:
- Internal registers: acc, mcand, mplier (32 b each); cnt (6 b, counts 0..ITERS).
- States: IDLE, CHECK, ADD, SHL, SHR, DONE.
- Reset: state=IDLE, ready=1, busy=0, done=0, result=0, acc=mcand=mplier=0, cnt=0. Reset wins over start; reset mid-operation aborts with no done pulse.
- IDLE: start=1 -> mcand<=op_a, mplier<=op_b, acc<=0, cnt<=0, go to CHECK.
- start while busy is ignored; it is neither queued nor an error.
- CHECK, no ALU use:
  - cnt==ITERS -> DONE.
  - Else if mplier[0]=1 -> ADD.
  - Else -> SHL.
  - (See the Optional Feature for early termination.)
- ADD: alu_a=acc, alu_b=mcand, alu_opcode=OP_ADD; acc<=alu_out; -> SHL.
- SHL: alu_a=mcand, alu_b=1, alu_opcode=OP_SLL; mcand<=alu_out; -> SHR.
- SHR: alu_a=mplier, alu_b=1, alu_opcode=OP_SRL; mplier<=alu_out; cnt<=cnt+1; -> CHECK.
- DONE: done=1, result<=acc on entry (visible in the DONE cycle); next edge -> IDLE. done is low in all other states.
- ALU outputs in IDLE, CHECK and DONE: alu_a=0, alu_b=0, alu_opcode=OP_ADD. Opcode is never left undefined, so the ALU case never latches.
- Arithmetic: modulo 2^32 throughout; overflow is discarded, no flag. Operands are treated as unsigned bit patterns; the low 32 bits equal the signed product as well.
- Latency, measured from the accept edge to the done cycle inclusive: 3 per iteration + 1 per set multiplier bit + 2.
- The multiply completes without any dependence on other ALU users. The pipeline holds its ALU mux on alu_* while busy=1.

Optional Feature:
- Macro: MUL_EARLY_TERM_EN.
- Defined: CHECK also goes to DONE when mplier==0, giving data-dependent short latency.
- Undefined: always runs ITERS iterations. Latency is 3*ITERS + popcount(op_b) + 2 (100 cycles for op_b=5).
- result is identical in both builds.

Test Plan:
- op_a=3, op_b=5, start for 1 cycle, early-term build -> ALU opcode sequence ADD,SLL,SRL,SLL,SRL,ADD,SLL,SRL; done in cycle 13 after accept; result=15.
- Same stimulus, macro undefined -> done in cycle 100; result=15; exactly two OP_ADD cycles observed.
- op_a=0xFFFFFFFF, op_b=2 -> result=0xFFFFFFFE; op_a=0x80000000, op_b=2 -> result=0.
- op_b=0, early-term build -> done in cycle 2; result=0; no OP_ADD cycle.
- Assert start every cycle during a multiply of 7*6 -> only the first request is accepted; result=42; ready low until done+1.
- rst=1 during the SHL of a 9*9 multiply -> next cycle IDLE, ready=1, busy=0, result=0, no done pulse. A following 2*3 multiply -> result=6.
